// File: rtl/zap_shifter_pipe.sv
// Pipelined, parametrised barrel shifter with valid/ready handshake, flush and tag.
// Result is computed combinationally at the input, then carried through STAGES slices.
`timescale 1ns/1ps
module zap_shifter_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 1,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_source,
  input  logic [7:0]            i_amount,
  input  logic                  i_carry,
  input  logic [2:0]            i_op,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_carry,
  output logic                  o_sat,
  output logic                  o_illegal,
  output logic [TAG_WIDTH-1:0]  o_tag
);

  localparam int         LW = $clog2(DATA_WIDTH);
  localparam int         PW = TAG_WIDTH + 3 + DATA_WIDTH;
  localparam logic [7:0] W8 = 8'(DATA_WIDTH);

  localparam logic [2:0] OP_LSL     = 3'd0;
  localparam logic [2:0] OP_LSR     = 3'd1;
  localparam logic [2:0] OP_ASR     = 3'd2;
  localparam logic [2:0] OP_ROR     = 3'd3;
  localparam logic [2:0] OP_RRX     = 3'd4;
  localparam logic [2:0] OP_LSL_SAT = 3'd5;

  // Shift left by one; clamp to the extreme of the original sign when the MSB flips.
  // Returns {sat, result}.
  function automatic logic [DATA_WIDTH:0] sat_lsl(input logic signed [DATA_WIDTH-1:0] src);
    logic signed [DATA_WIDTH-1:0] sh;
    logic                         sat;
    sh  = src <<< 1;
    sat = sh[DATA_WIDTH-1] != src[DATA_WIDTH-1];
    if (sat) begin
      if (src[DATA_WIDTH-1]) sh = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else                   sh = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
    return {sat, sh};
  endfunction

  // Returns {illegal, sat, carry, result}.
  function automatic logic [DATA_WIDTH+2:0] shift_op(
    input logic [2:0]                   op,
    input logic [7:0]                   n,
    input logic                         cin,
    input logic signed [DATA_WIDTH-1:0] src
  );
    logic [DATA_WIDTH-1:0] res;
    logic [DATA_WIDTH-1:0] rot;
    logic [DATA_WIDTH:0]   satv;
    logic [LW-1:0]         nm1;
    logic [LW-1:0]         wmn;
    logic [LW-1:0]         r;
    logic                  c;
    logic                  sat;
    logic                  ill;
    res  = src;
    c    = cin;
    sat  = 1'b0;
    ill  = 1'b0;
    nm1  = LW'(n - 8'd1);
    wmn  = LW'(W8 - n);
    r    = n[LW-1:0];
    rot  = DATA_WIDTH'({src, src} >> r);
    satv = sat_lsl(src);
    case (op)
      OP_LSL: begin
        if (n == 8'd0) begin
        end else if (n <= W8) begin
          res = src << n;
          c   = src[wmn];
        end else begin
          res = '0;
          c   = 1'b0;
        end
      end
      OP_LSR: begin
        if (n == 8'd0) begin
        end else if (n <= W8) begin
          res = src >> n;
          c   = src[nm1];
        end else begin
          res = '0;
          c   = 1'b0;
        end
      end
      OP_ASR: begin
        if (n == 8'd0) begin
        end else if (n < W8) begin
          res = src >>> n;
          c   = src[nm1];
        end else begin
          res = {DATA_WIDTH{src[DATA_WIDTH-1]}};
          c   = src[DATA_WIDTH-1];
        end
      end
      OP_ROR: begin
        // A nonzero multiple of the width leaves the value but still drives the carry.
        if (n == 8'd0) begin
        end else if (r == '0) begin
          c = src[DATA_WIDTH-1];
        end else begin
          res = rot;
          c   = rot[DATA_WIDTH-1];
        end
      end
      OP_RRX: begin
        res = {cin, src[DATA_WIDTH-1:1]};
        c   = src[0];
      end
      OP_LSL_SAT: begin
        res = satv[DATA_WIDTH-1:0];
        sat = satv[DATA_WIDTH];
        c   = 1'b0;
      end
      default: ill = 1'b1;
    endcase
    return {ill, sat, c, res};
  endfunction

  logic [PW-1:0] pay_in;
  assign pay_in = {i_tag, shift_op(i_op, i_amount, i_carry, i_source)};

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic          vld_p;
    logic [PW-1:0] pay_p;
    logic          load;
    logic          adv;
    logic          prev_vld;
    logic [PW-1:0] prev_pay;

    if (s == 0) begin : g_head
      assign prev_vld = i_valid;
      assign prev_pay = pay_in;
    end else begin : g_body
      assign prev_vld = g_stage[s-1].vld_p;
      assign prev_pay = g_stage[s-1].pay_p;
    end

    if (s == STAGES - 1) begin : g_tail
      assign adv = i_ready;
    end else begin : g_link
      assign adv = g_stage[s+1].load;
    end

    // Stage boundary: a slice refills when empty or when its occupant moves on this edge.
    assign load = !vld_p || adv;

    always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) vld_p <= 1'b0;
      else if (load)          vld_p <= prev_vld;
    end

    always_ff @(posedge i_clk) begin
      if (load) pay_p <= prev_pay;
    end
  end

  assign o_ready = g_stage[0].load;
  assign o_valid = g_stage[STAGES-1].vld_p;
  // Fields read zero whenever nothing is presented, so reset and flush leave a clean output.
  assign {o_tag, o_illegal, o_sat, o_carry, o_result} =
    g_stage[STAGES-1].vld_p ? g_stage[STAGES-1].pay_p : '0;

endmodule

// File: tb/tb_zap_shifter_pipe.sv
// Bench for zap_shifter_pipe: a 32-bit/2-stage and a 64-bit/3-stage instance, each with
// a scoreboard queue filled at input transfer and drained at output transfer.
`timescale 1ns/1ps
module tb_zap_shifter_pipe;

  localparam logic [2:0] LSL = 3'd0, LSR = 3'd1, ASR = 3'd2, ROR = 3'd3;
  localparam logic [2:0] RRX = 3'd4, SAT = 3'd5, IL6 = 3'd6, IL7 = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_clear, a_valid, a_ready, a_cin, a_iready, a_ovalid;
  logic        a_carry, a_sat, a_ill;
  logic [31:0] a_src, a_res;
  logic [7:0]  a_amt, a_tag, a_otag;
  logic [2:0]  a_op;

  logic        b_reset, b_clear, b_valid, b_ready, b_cin, b_iready, b_ovalid;
  logic        b_carry, b_sat, b_ill;
  logic [63:0] b_src, b_res;
  logic [7:0]  b_amt, b_tag, b_otag;
  logic [2:0]  b_op;

  zap_shifter_pipe #(.DATA_WIDTH(32), .STAGES(2), .TAG_WIDTH(8)) dut_a (
    .i_clk(clk), .i_reset(a_reset), .i_clear(a_clear), .i_valid(a_valid), .o_ready(a_ready),
    .i_source(a_src), .i_amount(a_amt), .i_carry(a_cin), .i_op(a_op), .i_tag(a_tag),
    .o_valid(a_ovalid), .i_ready(a_iready), .o_result(a_res), .o_carry(a_carry),
    .o_sat(a_sat), .o_illegal(a_ill), .o_tag(a_otag));

  zap_shifter_pipe #(.DATA_WIDTH(64), .STAGES(3), .TAG_WIDTH(8)) dut_b (
    .i_clk(clk), .i_reset(b_reset), .i_clear(b_clear), .i_valid(b_valid), .o_ready(b_ready),
    .i_source(b_src), .i_amount(b_amt), .i_carry(b_cin), .i_op(b_op), .i_tag(b_tag),
    .o_valid(b_ovalid), .i_ready(b_iready), .o_result(b_res), .o_carry(b_carry),
    .o_sat(b_sat), .o_illegal(b_ill), .o_tag(b_otag));

  typedef struct {
    logic [63:0] res;
    logic        c;
    logic        sat;
    logic        ill;
    logic [7:0]  tag;
  } exp_t;

  typedef struct {
    bit          w64;
    logic [2:0]  op;
    logic [7:0]  amt;
    logic        cin;
    logic [63:0] src;
    logic [63:0] res;
    logic        c;
    logic        sat;
    logic        ill;
  } vec_t;

  vec_t vecs[$];
  exp_t qa[$], qb[$];
  exp_t a_exp, b_exp;
  int   total = 0, bad = 0, a_outs = 0, b_outs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_reset || a_clear) qa.delete();
    else begin
      if (a_ovalid && a_iready) begin
        a_outs++;
        if (qa.size() == 0) fail_now($sformatf("a_unexpected_output tag=%h", a_otag));
        else begin
          e = qa.pop_front();
          chk("a_result", 64'(a_res), e.res);
          chk("a_carry", 64'(a_carry), 64'(e.c));
          chk("a_sat", 64'(a_sat), 64'(e.sat));
          chk("a_illegal", 64'(a_ill), 64'(e.ill));
          chk("a_tag", 64'(a_otag), 64'(e.tag));
        end
      end
      if (a_valid && a_ready) qa.push_back(a_exp);
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_reset || b_clear) qb.delete();
    else begin
      if (b_ovalid && b_iready) begin
        b_outs++;
        if (qb.size() == 0) fail_now($sformatf("b_unexpected_output tag=%h", b_otag));
        else begin
          e = qb.pop_front();
          chk("b_result", b_res, e.res);
          chk("b_carry", 64'(b_carry), 64'(e.c));
          chk("b_sat", 64'(b_sat), 64'(e.sat));
          chk("b_illegal", 64'(b_ill), 64'(e.ill));
          chk("b_tag", 64'(b_otag), 64'(e.tag));
        end
      end
      if (b_valid && b_ready) qb.push_back(b_exp);
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge, valid low.
  task automatic drive(input bit w64, input logic [2:0] op, input logic [7:0] amt,
                       input logic cin, input logic [63:0] src, input logic [63:0] res,
                       input logic c, input logic sat, input logic ill, input logic [7:0] tag);
    exp_t e;
    bit   ok;
    e.res = res; e.c = c; e.sat = sat; e.ill = ill; e.tag = tag;
    if (!w64) begin
      a_op = op; a_amt = amt; a_cin = cin; a_src = src[31:0]; a_tag = tag; a_exp = e;
      a_valid = 1'b1;
    end else begin
      b_op = op; b_amt = amt; b_cin = cin; b_src = src; b_tag = tag; b_exp = e;
      b_valid = 1'b1;
    end
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (w64 ? b_ready : a_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now($sformatf("accept_timeout tag=%h", tag));
    @(posedge clk); #1;
    if (!w64) a_valid = 1'b0;
    else      b_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(negedge clk);
    end
    if (qa.size() != 0 || qb.size() != 0)
      fail_now($sformatf("drain_timeout qa=%0d qb=%0d", qa.size(), qb.size()));
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   outs0;
    a_reset = 1; a_clear = 0; a_valid = 0; a_src = '0; a_amt = '0; a_cin = 0; a_op = '0;
    a_tag = '0; a_iready = 1;
    b_reset = 1; b_clear = 0; b_valid = 0; b_src = '0; b_amt = '0; b_cin = 0; b_op = '0;
    b_tag = '0; b_iready = 1;
    a_exp = '{64'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    b_exp = a_exp;

    // 32-bit vectors
    vecs.push_back('{1'b0, ASR, 8'd40, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, LSR, 8'd32, 1'b0, 64'h8000_0000, 64'h0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, LSR, 8'd33, 1'b0, 64'h8000_0000, 64'h0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, SAT, 8'd7, 1'b1, 64'h4000_0000, 64'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, SAT, 8'd0, 1'b0, 64'hC000_0000, 64'h8000_0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, SAT, 8'd0, 1'b0, 64'h8000_0000, 64'h8000_0000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, IL7, 8'd3, 1'b1, 64'h1234_5678, 64'h1234_5678, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, IL6, 8'd0, 1'b0, 64'hA5A5_A5A5, 64'hA5A5_A5A5, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, LSL, 8'd0, 1'b1, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, LSL, 8'd32, 1'b0, 64'h0000_0001, 64'h0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, LSL, 8'd33, 1'b0, 64'hFFFF_FFFF, 64'h0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, ASR, 8'd5, 1'b0, 64'h8000_0010, 64'hFC00_0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, ASR, 8'd32, 1'b1, 64'h7FFF_FFFF, 64'h0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, ROR, 8'd8, 1'b0, 64'h1234_5678, 64'h7812_3456, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, ROR, 8'd36, 1'b0, 64'h0000_000F, 64'hF000_0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, ROR, 8'd32, 1'b0, 64'h8000_0001, 64'h8000_0001, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, ROR, 8'd0, 1'b0, 64'h8000_0000, 64'h8000_0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, RRX, 8'd9, 1'b0, 64'h0000_0003, 64'h0000_0001, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, LSR, 8'd0, 1'b1, 64'h0000_0005, 64'h0000_0005, 1'b1, 1'b0, 1'b0});
    // 64-bit vectors
    vecs.push_back('{1'b1, ROR, 8'd64, 1'b0, 64'h1, 64'h1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, ROR, 8'd1, 1'b0, 64'h1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, RRX, 8'd0, 1'b1, 64'h3, 64'h8000_0000_0000_0001, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, SAT, 8'd0, 1'b0, 64'h4000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
                     1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, LSL, 8'd64, 1'b0, 64'h1, 64'h0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, LSL, 8'd65, 1'b0, 64'h1, 64'h0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, ASR, 8'd63, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, ROR, 8'd130, 1'b0, 64'h5, 64'h4000_0000_0000_0001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, LSR, 8'd64, 1'b1, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b0, 1'b0});

    repeat (3) @(posedge clk);
    #1 a_reset = 0; b_reset = 0;

    @(negedge clk);
    chk("rst_a_valid", 64'(a_ovalid), 64'd0);
    chk("rst_a_result", 64'(a_res), 64'd0);
    chk("rst_a_flags", 64'({a_carry, a_sat, a_ill}), 64'd0);
    chk("rst_a_tag", 64'(a_otag), 64'd0);
    chk("rst_a_ready", 64'(a_ready), 64'd1);
    chk("rst_b_valid", 64'(b_ovalid), 64'd0);
    @(posedge clk); #1;

    // Latency of a single op on the two-stage instance
    a_op = LSL; a_amt = 8'd1; a_cin = 1'b0; a_src = 32'h8000_0001; a_tag = 8'h01;
    a_exp = '{64'h2, 1'b1, 1'b0, 1'b0, 8'h01};
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (a_ovalid) break;
    end
    chk("a_latency", 64'(lat), 64'd2);
    drain();

    for (int i = 0; i < vecs.size(); i++)
      drive(vecs[i].w64, vecs[i].op, vecs[i].amt, vecs[i].cin, vecs[i].src, vecs[i].res,
            vecs[i].c, vecs[i].sat, vecs[i].ill, 8'(8'h40 + i));
    drain();

    // Stream of six with a four-cycle output stall once the first result leaves
    outs0 = b_outs;
    fork
      begin
        for (int t = 1; t <= 6; t++)
          drive(1'b1, LSL, 8'd1, 1'b0, 64'(t), 64'(2 * t), 1'b0, 1'b0, 1'b0, 8'(t));
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (b_ovalid) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) fail_now("b_stream_first_output_timeout");
        @(posedge clk); #1 b_iready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("b_stall_valid", 64'(b_ovalid), 64'd1);
          chk("b_stall_tag", 64'(b_otag), 64'd2);
          chk("b_stall_ready", 64'(b_ready), 64'd0);
        end
        @(posedge clk); #1 b_iready = 1'b1;
      end
    join
    drain();
    chk("b_stream_count", 64'(b_outs - outs0), 64'd6);

    // Flush with three ops in flight and a new op offered on the same edge
    b_iready = 1'b0;
    for (int t = 0; t < 3; t++)
      drive(1'b1, RRX, 8'd0, 1'b1, 64'h10, 64'h8000_0000_0000_0008, 1'b0, 1'b0, 1'b0,
            8'(8'h21 + t));
    @(negedge clk);
    chk("b_pre_clear_valid", 64'(b_ovalid), 64'd1);
    @(posedge clk); #1;
    b_clear = 1'b1; b_valid = 1'b1; b_tag = 8'h24; b_op = LSR; b_amt = 8'd1; b_src = 64'h8;
    @(posedge clk); #1;
    b_clear = 1'b0; b_valid = 1'b0; b_iready = 1'b1;
    @(negedge clk);
    chk("b_clear_valid", 64'(b_ovalid), 64'd0);
    chk("b_clear_tag", 64'(b_otag), 64'd0);
    chk("b_clear_ready", 64'(b_ready), 64'd1);
    @(posedge clk); #1;
    outs0 = b_outs;
    drive(1'b1, LSR, 8'd4, 1'b0, 64'hF0, 64'hF, 1'b0, 1'b0, 1'b0, 8'h31);
    drive(1'b1, ASR, 8'd1, 1'b0, 64'h8000_0000_0000_0001, 64'hC000_0000_0000_0000,
          1'b1, 1'b0, 1'b0, 8'h32);
    drain();
    chk("b_after_clear_count", 64'(b_outs - outs0), 64'd2);

    // Reset mid-stream on the two-stage instance
    a_iready = 1'b0;
    drive(1'b0, IL7, 8'd0, 1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 8'h51);
    drive(1'b0, IL7, 8'd0, 1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 8'h52);
    @(negedge clk);
    chk("a_pre_reset_valid", 64'(a_ovalid), 64'd1);
    chk("a_pre_reset_tag", 64'(a_otag), 64'h51);
    @(posedge clk); #1;
    a_reset = 1'b1; a_valid = 1'b1; a_tag = 8'h53;
    @(posedge clk); #1;
    a_reset = 1'b0; a_valid = 1'b0; a_iready = 1'b1;
    @(negedge clk);
    chk("a_reset_valid", 64'(a_ovalid), 64'd0);
    chk("a_reset_result", 64'(a_res), 64'd0);
    chk("a_reset_flags", 64'({a_carry, a_sat, a_ill}), 64'd0);
    chk("a_reset_tag", 64'(a_otag), 64'd0);
    @(posedge clk); #1;
    outs0 = a_outs;
    drive(1'b0, LSR, 8'd1, 1'b0, 64'h0000_0003, 64'h0000_0001, 1'b1, 1'b0, 1'b0, 8'h61);
    drain();
    chk("a_after_reset_count", 64'(a_outs - outs0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zap_shifter_pipe.md
Name: zap_shifter_pipe

Overview:
- Parametrised, pipelined barrel shifter; generalises the ZAP 32-bit combinational shifter to DATA_WIDTH bits.
- Adds a configurable register depth, valid/ready handshake with back-pressure, pipeline flush and a pass-through tag.
- Sits between the issue/operand-fetch path and the ALU; a wide-datapath or high-frequency build uses it in place of the single-cycle shifter.

Parameters:
DATA_WIDTH, 32, operand width; legal values 16, 32, 64.
STAGES, 1, register stages from input to output; legal range 1..3; equals latency.
TAG_WIDTH, 8, sideband tag width carried alongside each operation (>=1).

Ports:
i_clk  in  1  clock; all logic is on the rising edge.
i_reset  in  1  synchronous, active-high reset.
i_clear  in  1  synchronous flush of all in-flight operations.
i_valid  in  1  input operation valid.
o_ready  out  1  shifter accepts an input this cycle.
i_source  in  DATA_WIDTH  value to be shifted.
i_amount  in  8  shift amount, unsigned.
i_carry  in  1  carry in.
i_op  in  3  operation: 0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX, 5 LSL_SAT, 6-7 illegal.
i_tag  in  TAG_WIDTH  opaque tag, returned unchanged.
o_valid  out  1  output valid.
i_ready  in  1  downstream accepts the output.
o_result  out  DATA_WIDTH  shifted result.
o_carry  out  1  shifter carry out.
o_sat  out  1  saturation occurred (LSL_SAT only).
o_illegal  out  1  operation code was 6 or 7.
o_tag  out  TAG_WIDTH  tag of the output operation.

Behaviour:
- Clock and reset: one clock, i_clk. i_reset is synchronous and active-high. On reset every stage's valid bit clears, and o_valid, o_result, o_carry, o_sat, o_illegal and o_tag all read 0. Reset takes priority over i_clear and over any transfer, including mid-stream.
- Transfers: an input transfer happens when i_valid && o_ready; an output transfer when o_valid && i_ready.
- Pipeline: the result is computed combinationally from the inputs, then carried through STAGES register slices. Implementers may retime the logic across the slices.
- Stage advance: each stage loads when it is empty or when its contents move on in the same cycle. o_ready = !stage0_valid || stage0 advances, i.e. a full pipeline with i_ready=1 takes one operation per cycle.
- Latency: with i_ready held at 1, an operation accepted in cycle N appears on o_valid in cycle N+STAGES.
- Stall: when o_valid=1 and i_ready=0, all output fields stay stable, and no stage's contents are lost or duplicated.
- Flush: i_clear=1 zeroes every stage's valid bit at the next edge. An input presented with i_clear is dropped. Data registers may keep stale values.
- Operation rules (W = DATA_WIDTH, n = i_amount):
  - LSL: n=0 gives result=src, carry=cin. 1<=n<=W gives src<<n, carry=src[W-n]. n>W gives result 0, carry 0.
  - LSR: n=0 passes through (result=src, carry=cin). 1<=n<=W gives src>>n, carry=src[n-1]. n>W gives result 0, carry 0.
  - ASR: n=0 passes through. 1<=n<W gives arithmetic shift, carry=src[n-1]. n>=W gives result of all src[W-1], carry=src[W-1].
  - ROR: n=0 passes through. n mod W = 0 with n!=0 gives result=src, carry=src[W-1]. Otherwise rotate right by n mod W, carry=result[W-1].
  - RRX: result={cin, src[W-1:1]}, carry=src[0]; n is ignored.
  - LSL_SAT: always shift by 1; n is ignored. If the MSB changes, o_sat=1 and result saturates: 0111..1 when src[W-1]=0, 1000..0 when src[W-1]=1. carry=0.
  - Illegal (op 6 or 7): result=src, carry=cin, o_sat=0, o_illegal=1.
  - o_sat and o_illegal are 0 for every other operation.
- Widths: log2(W) low bits of n select the rotate; the full 8 bits of n decide the over-range cases.

Test Plan:
- W=32, STAGES=2, i_ready=1; LSL src=0x8000_0001, n=1, cin=0 -> two cycles later result 0x0000_0002, carry 1.
- W=32: ASR src=0x8000_0000, n=40 -> 0xFFFF_FFFF, carry 1. LSR same src, n=32 -> 0, carry 1. LSR n=33 -> 0, carry 0.
- W=64, STAGES=3: ROR src=0x1, n=64 -> result 0x1, carry 0. ROR n=1 -> 0x8000_0000_0000_0000, carry 1. RRX with cin=1 and src=0x3 -> 0x8000_0000_0000_0001, carry 1.
- W=32: LSL_SAT src=0x4000_0000 -> 0x7FFF_FFFF, o_sat 1. LSL_SAT src=0xC000_0000 -> 0x8000_0000, o_sat 0. op=7 -> result=src, o_illegal 1.
- STAGES=3: stream 6 ops with tags 1..6 and hold i_ready=0 for 4 cycles mid-stream -> o_ready deasserts once 3 ops are buffered, and outputs emerge in order 1..6 with no drop or duplicate.
- Assert i_clear with 3 ops in flight, plus i_valid in the same cycle -> o_valid=0 from the next cycle, and no tag from before the clear ever appears. Repeat the same sequence with i_reset -> every output reads 0.
